// File: rtl/prio_drain.sv
// prio_drain: accumulates request pulses and drains them one at a time, highest index first
module prio_drain #(
    parameter int DW = 32,
    localparam int IW = $clog2(DW),
    localparam int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [DW-1:0] set,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_onehot,
    output logic [IW-1:0] out_index,
    output logic [DW-1:0] pending,
    output logic [CW-1:0] count
);
    logic [DW-1:0] pending_q, sel_q, cand;
    logic          hold_q;
    logic [IW-1:0] cand_index;
    logic          acc;

    // highest pending bit wins; a stalled grant stays frozen in sel_q so late arrivals cannot preempt it
    always_comb begin
        cand_index = '0;
        out_index  = '0;
        count      = '0;
        for (int i = 0; i < DW; i++) begin
            cand_index = pending_q[i] ? IW'(i) : cand_index;
            count      = count + CW'(pending_q[i]);
        end
        cand       = |pending_q ? DW'(1) << cand_index : '0;
        out_onehot = hold_q ? sel_q : cand;
        for (int i = 0; i < DW; i++)
            out_index = out_index | (out_onehot[i] ? IW'(i) : '0);
        out_valid  = |pending_q;
        pending    = pending_q;
        acc        = out_valid & out_ready;
    end

    // accepted bit clears unless re-set in the same cycle; flush keeps only this cycle's new requests
    always_ff @(posedge clk) begin
        if (!nreset) begin
            pending_q <= '0;
            hold_q    <= 1'b0;
            sel_q     <= '0;
        end else if (flush) begin
            pending_q <= set;
            hold_q    <= 1'b0;
            sel_q     <= '0;
        end else begin
            pending_q <= (pending_q & ~(acc ? out_onehot : '0)) | set;
            hold_q    <= out_valid & ~out_ready;
            sel_q     <= out_onehot;
        end
    end
endmodule

// File: tb/tb_prio_drain.sv
// tb_prio_drain: randomized scoreboard bench for prio_drain against a queue-free bit-array model
module tb_prio_drain;
    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] set = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic [2:0] out_index;
    logic [7:0] pending;
    logic [3:0] count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       v;
        logic [7:0] oh;
        logic [2:0] idx;
        logic [7:0] p;
        logic [3:0] c;
    } exp_t;
    exp_t q[$];

    logic [7:0] m_pend = '0;
    int         m_held = -1;

    prio_drain #(.DW(8)) dut (
        .clk(clk), .nreset(nreset), .set(set), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .out_index(out_index), .pending(pending), .count(count)
    );

    always #5 clk = ~clk;

    function automatic int top_bit(logic [7:0] p);
        for (int i = 7; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    function automatic int grant();
        return (m_held >= 0) ? m_held : top_bit(m_pend);
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int g;
        g     = grant();
        e.v   = (m_pend != 0);
        e.oh  = e.v ? (8'd1 << g) : 8'd0;
        e.idx = e.v ? 3'(g) : 3'd0;
        e.p   = m_pend;
        e.c   = 4'($countones(m_pend));
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(logic n, logic [7:0] s, logic f, logic r);
        int  g;
        logic v;
        nreset    = n;
        set       = s;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        g = grant();
        v = (m_pend != 0);
        if (!n) begin
            m_pend = '0;
            m_held = -1;
        end else if (f) begin
            m_pend = s;
            m_held = -1;
        end else begin
            if (v && r) m_pend[g] = 1'b0;
            m_pend = m_pend | s;
            m_held = (v && !r) ? g : -1;
        end
        q.push_back(expect_now());
        #1;
    endtask

    // compare every registered-state observation against the model, half a cycle after the edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_valid", int'(out_valid), int'(e.v));
            chk("out_onehot", int'(out_onehot), int'(e.oh));
            chk("out_index", int'(out_index), int'(e.idx));
            chk("pending", int'(pending), int'(e.p));
            chk("count", int'(count), int'(e.c));
        end
    end

    initial begin
        cyc(0, 8'hFF, 0, 0); cyc(0, 8'hFF, 0, 0);
        cyc(1, 8'h00, 0, 0); cyc(1, 8'h00, 0, 0);
        cyc(1, 8'h29, 0, 1);
        repeat (4) cyc(1, 8'h00, 0, 1);
        cyc(1, 8'h09, 0, 0); cyc(1, 8'h00, 0, 0);
        cyc(1, 8'h80, 0, 0); cyc(1, 8'h00, 0, 0);
        repeat (3) cyc(1, 8'h00, 0, 1);
        cyc(1, 8'h04, 0, 1); cyc(1, 8'h04, 0, 1);
        repeat (2) cyc(1, 8'h00, 0, 1);
        cyc(1, 8'hF0, 0, 0); cyc(1, 8'h00, 0, 0);
        cyc(1, 8'h02, 1, 0);
        repeat (2) cyc(1, 8'h00, 0, 1);
        cyc(1, 8'hFF, 0, 0); cyc(1, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h10, 0, 0);
        repeat (2) cyc(1, 8'h00, 0, 1);
        for (int k = 0; k < 2000; k++)
            cyc($urandom_range(0, 99) != 0,
                ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 7);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain_queue actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prio_drain.md
Name: prio_drain

Overview:
- Sequential counterpart to the combinational priority encoder: the consumer end of a one-hot grant interface.
- Accumulates asynchronous request pulses into a pending register.
- Drains pending requests one at a time, highest index first, as one-hot plus binary index over a valid/ready handshake.
- Accepted bits are cleared. Sits between request sources (interrupt lines, event flags) and a single-issue consumer.

Parameters:
- DW, 32, data width (number of request lines), must be >= 2.
- IW, $clog2(DW), width of the binary index output. Derived; do not override.
- CW, $clog2(DW+1), width of the pending-count output. Derived; do not override.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- nreset  input  1  reset, synchronous, active-low.
- set  input  DW  request pulses; bit i high for one or more cycles marks request i pending.
- flush  input  1  discard all pending requests and any held grant.
- out_valid  output  1  a grant is presented.
- out_ready  input  1  consumer accepts the presented grant this cycle.
- out_onehot  output  DW  one-hot grant; all zero when out_valid=0.
- out_index  output  IW  binary index of the granted bit; 0 when out_valid=0.
- pending  output  DW  current pending register.
- count  output  CW  population count of pending.

Behaviour:
- State: pending_q[DW], hold_q (1b), sel_q[DW]. Reset (nreset=0 at a clk edge) clears all three. Reset has priority over every other input.
- Outputs after reset: out_valid=0, out_onehot=0, out_index=0, pending=0, count=0.
- Candidate: cand = one-hot of the highest set bit of pending_q (MSB wins); 0 if pending_q=0.
- Presented grant:
  - out_onehot = hold_q ? sel_q : cand.
  - out_valid = |pending_q. The held bit always remains in pending_q until accepted.
  - out_index = binary encoding of out_onehot.
  - All outputs are combinational from registered state only. There is no combinational path from set, flush or out_ready to any output.
- Latency: set bit at edge N produces pending/out_valid from edge N (visible the cycle after set is sampled), i.e. 1 cycle.
- Accept: acc = out_valid & out_ready.
- Next-state, flush=0:
  - pending_q <= (pending_q & ~(acc ? out_onehot : 0)) | set.
  - hold_q <= out_valid & ~out_ready.
  - sel_q <= out_onehot when out_valid & ~out_ready; otherwise don't-care, reset value 0.
- Stability rule: once presented and not accepted, out_onehot/out_index must not change. A higher-priority set arriving during a stall does not preempt. It is granted next, after the held grant is accepted.
- After acceptance, the next cycle presents the new highest pending bit. This gives one grant per cycle at full throughput.
- Simultaneous accept and set of the same bit: set wins. The bit stays pending and is re-granted by normal priority.
- Set of an already-pending bit: no effect. Requests do not queue; count does not change.
- Flush=1 (nreset=1): pending_q <= set, hold_q <= 0. An acceptance in the same cycle is ignored, which has no effect since flush clears it anyway.
- count = popcount(pending_q), range 0..DW.

Test Plan:
- Reset: drive set=0xFF with nreset=0 for 2 cycles (DW=8) -> out_valid=0, pending=0x00, count=0. Release reset with set=0 -> outputs stay 0.
- Drain order: set=0x29 for one cycle, out_ready=1 -> the following cycles present (0x20, idx 5, count 3), (0x08, idx 3, count 2), (0x01, idx 0, count 1), then out_valid=0, count=0.
- Stall/no preempt: pending=0x09, out_ready=0 -> 0x08/idx3 presented. Pulse set=0x80 -> output stays 0x08 while stalled; pending=0x89, count=3. Then out_ready=1 -> next cycles present 0x80, then 0x01.
- Same-bit collision: pending=0x04, out_ready=1, set=0x04 in the accept cycle -> next cycle out_valid=1, out_onehot=0x04, count=1.
- Flush: pending=0xF0 with 0x80 held (out_ready=0); flush=1, set=0x02 -> next cycle pending=0x02, out_onehot=0x02, idx 1, count=1, hold cleared.
- Reset mid-operation: pending=0xFF, stalled on 0x80; nreset=0 for one edge -> all outputs 0 next cycle. A subsequent set=0x10 -> 0x10 presented, idx 4.
